md5_block_formatter: RTL and testbench
======================================

// Module: md5_block_formatter
// PURPOSE
//  Message-side responder for the MD5 hashing path: accepts one candidate word (<=16 bytes) from the
//  brute-force controller over a valid/ready handshake. Applies RFC 1321 padding (0x80, zero fill,
//  64-bit little-endian bit length) and streams the single 512-bit block as sixteen 32-bit M[i] words
//  to the MD5 round engine. Sits between the guess generator/controller and the round core.
// PARAMETERS
//  MSG_W    128  candidate word width in bits; byte k of the message = msg_in[MSG_W-1-8k -: 8]
//  WIDTH_W  8    width of msg_in_width; must hold the value MSG_W
// PORTS
//  clock          in   1        rising-edge clock
//  reset          in   1        asynchronous, active-high
//  msg_in         in   MSG_W    candidate word, byte 0 in MSBs
//  msg_in_width   in   WIDTH_W  message length in bits (multiple of 8, 0..MSG_W)
//  msg_in_valid   in   1        msg_in/msg_in_width valid
//  msg_in_ready   out  1        formatter can accept a message
//  m_word         out  32       current M[m_index], little-endian packed
//  m_index        out  4        word index 0..15
//  m_valid        out  1        m_word valid
//  m_ready        in   1        round engine accepts m_word
//  m_last         out  1        high with m_valid when m_index==15
//  fmt_err        out  1        (MD5_FMT_ERR_EN only) one-cycle pulse on illegal width
// BEHAVIOUR
//  - Reset: state IDLE, msg_in_ready=1, m_valid=0, m_last=0, m_index=0, m_word=0, fmt_err=0, latched msg=0.
//  - FSM: IDLE -> EMIT on msg_in_valid&&msg_in_ready (edge T); latch msg and n=byte count.
//    EMIT: m_valid=1 from T+1, m_index starts at 0; index increments on each m_valid&&m_ready.
//    EMIT -> IDLE on acceptance of index 15 (m_last). msg_in_ready=1 only in IDLE; no overlap.
//  - Throughput: one block per 17 cycles at m_ready=1; m_ready low stalls with m_word/m_index held stable.
//  - Byte map: b[k]=msg byte k for k<n; b[n]=8'h80; b[k]=0 for n<k<56; b[56..63]=bit length LE.
//    M[i]={b[4i+3],b[4i+2],b[4i+1],b[4i]}. With n<=16: M[14]=8*n, M[15]=0.
//  - n=16: M[0..3]=message, M[4]=32'h00000080, M[14]=32'h00000080.
//  - n=0: M[0]=32'h00000080, all others 0.
//  - m_word combinational from latched registers and m_index only (no input path to output).
//  - Illegal width: width>MSG_W clamps n=16; width[2:0]!=0 truncates (n=width>>3).
//  - msg_in_valid while not ready: ignored; upstream holds. msg inputs ignored outside acceptance edge.
//  - Async reset mid-EMIT: block discarded, outputs to reset values immediately, IDLE on release.
// CONFIGURATION
//  MD5_FMT_ERR_EN defined: fmt_err port present; pulses 1 cycle (T+1) when an accepted width is >MSG_W
//   or not a multiple of 8; clamp/truncate still applied.
//  Not defined: no fmt_err port; clamp/truncate silently.
// STRUCTURE
//  md5_pkg: MD5_BLOCK_WORDS=16, MD5_PAD_BYTE=8'h80, MD5_LEN_IDX=14, state typedef {IDLE,EMIT}.
//  Sub-module md5_word_select: combinational; (latched msg, n, index) -> M[index]. Top holds FSM/counter.
// TESTING
//  1 "abc" (msg_in=24'h616263 in MSBs, width=24), m_ready=1 -> M0=32'h80636261, M14=32'h18, others 0,
//    m_last at index 15, msg_in_ready back high the cycle after.
//  2 width=0 -> M0=32'h00000080, M1..M15=0.
//  3 16-byte "0123456789abcdef", width=128 -> M0=32'h33323130, M4=32'h80, M14=32'h80.
//  4 m_ready toggled randomly during block -> exactly 16 accepted words, in order, stable while stalled.
//  5 Assert reset at index 7 -> m_valid=0 immediately; new msg after release restarts at index 0.
//  6 width=200 and width=20 -> n=16 / n=2 respectively; fmt_err pulses once each iff MD5_FMT_ERR_EN.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared constants and FSM state type for the MD5 message-formatting path.
package md5_pkg;

  localparam int         MD5_BLOCK_WORDS = 16;
  localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;
  localparam int         MD5_LEN_IDX     = 14;

  typedef enum logic {IDLE, EMIT} fmt_state_e;

endpackage

// File: rtl/md5_word_select.sv
// Combinational view of the padded 512-bit block: (message, byte count, index) -> M[index].
module md5_word_select
  import md5_pkg::*;
#(
  parameter int MSG_W = 128,
  parameter int NB    = MSG_W / 8,
  parameter int NW    = $clog2(NB + 1)
) (
  input  logic [MSG_W-1:0] msg,
  input  logic [NW-1:0]    n,
  input  logic [3:0]       index,
  output logic [31:0]      word
);

  localparam int MBW = (NB > 1) ? $clog2(NB) : 1;

  logic [NB-1:0][7:0] mb;
  logic [63:0][7:0]   blk;
  logic [63:0]        bit_len;

  // Byte 0 of the message sits in the MSBs of msg.
  for (genvar g = 0; g < NB; g++) begin : g_bytes
    assign mb[g] = msg[MSG_W-1-8*g -: 8];
  end

  assign bit_len = 64'(n) << 3;

  always_comb begin
    blk = '0;
    for (int k = 0; k < NB; k++)
      if (k < int'(n)) blk[6'(k)] = mb[MBW'(k)];
    blk[6'(n)] = MD5_PAD_BYTE;
    for (int k = 0; k < 8; k++)
      blk[6'(MD5_LEN_IDX*4 + k)] = bit_len[8*k +: 8];
    word = {blk[{index, 2'd3}], blk[{index, 2'd2}], blk[{index, 2'd1}], blk[{index, 2'd0}]};
  end

endmodule

// File: rtl/md5_block_formatter.sv
// Accepts one short message, streams its single padded MD5 block as 16 little-endian words.
// Optional MD5_FMT_ERR_EN adds a fmt_err pulse for illegal message widths.
module md5_block_formatter
  import md5_pkg::*;
#(
  parameter int MSG_W   = 128,
  parameter int WIDTH_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [MSG_W-1:0]   msg_in,
  input  logic [WIDTH_W-1:0] msg_in_width,
  input  logic               msg_in_valid,
  output logic               msg_in_ready,
  output logic [31:0]        m_word,
  output logic [3:0]         m_index,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last
`ifdef MD5_FMT_ERR_EN
  ,
  output logic               fmt_err
`endif
);

  localparam int NB = MSG_W / 8;
  localparam int NW = $clog2(NB + 1);

  fmt_state_e       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [MSG_W-1:0] msg_q;
  logic [NW-1:0]    n_q, n_in;
  logic             load, width_over;
  logic [31:0]      sel_word;

  // Over-long widths clamp to a full message; odd bit counts truncate to whole bytes.
  assign width_over = msg_in_width > WIDTH_W'(MSG_W);
  assign n_in       = width_over ? NW'(NB) : NW'(msg_in_width >> 3);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (msg_in_valid) begin
        load    = 1'b1;
        state_d = EMIT;
        idx_d   = '0;
      end
      EMIT: if (m_ready) begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(MD5_BLOCK_WORDS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      msg_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        msg_q <= msg_in;
        n_q   <= n_in;
      end
    end
  end

`ifdef MD5_FMT_ERR_EN
  logic width_bad;
  assign width_bad = width_over || (msg_in_width[2:0] != 3'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) fmt_err <= 1'b0;
    else       fmt_err <= load && width_bad;
  end
`endif

  md5_word_select #(.MSG_W(MSG_W)) u_sel (
    .msg   (msg_q),
    .n     (n_q),
    .index (idx_q),
    .word  (sel_word)
  );

  assign msg_in_ready = (state_q == IDLE);
  assign m_valid      = (state_q == EMIT);
  assign m_index      = idx_q;
  assign m_last       = m_valid && (idx_q == 4'(MD5_BLOCK_WORDS - 1));
  // Gate on m_valid so the idle/reset word reads zero rather than the n=0 pad pattern.
  assign m_word       = m_valid ? sel_word : 32'd0;

endmodule

// File: tb/tb_md5_block_formatter.sv
// Randomized bench for md5_block_formatter against a byte-array padding model.
module tb_md5_block_formatter;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] msg_in;
  logic [7:0]   msg_in_width;
  logic         msg_in_valid;
  logic         msg_in_ready;
  logic [31:0]  m_word;
  logic [3:0]   m_index;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
`ifdef MD5_FMT_ERR_EN
  logic         fmt_err;
`endif

  int tests = 0, fails = 0;
  int dut_acc = 0, nblocks = 0, err_seen = 0;
  bit rand_ready = 0;

  md5_block_formatter dut (
    .clock        (clock),
    .reset        (reset),
    .msg_in       (msg_in),
    .msg_in_width (msg_in_width),
    .msg_in_valid (msg_in_valid),
    .msg_in_ready (msg_in_ready),
    .m_word       (m_word),
    .m_index      (m_index),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last)
`ifdef MD5_FMT_ERR_EN
    ,
    .fmt_err      (fmt_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // RFC 1321 single-block padding built straight from a 64-byte array.
  function automatic logic [31:0] mword(input logic [127:0] m, input logic [7:0] w, input int i);
    logic [7:0] b [64];
    int n, len;
    n = (w > 8'd128) ? 16 : int'(w) / 8;
    for (int k = 0; k < 64; k++) b[k] = 8'h00;
    for (int k = 0; k < n; k++) b[k] = m[127-8*k -: 8];
    b[n] = 8'h80;
    len = 8 * n;
    for (int j = 0; j < 4; j++) b[56+j] = 8'((len >> (8*j)) & 255);
    return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
  endfunction

  // Reference state, advanced from the inputs seen before each rising edge.
  bit          busy = 0, err_next = 0;
  int          idx = 0;
  logic [31:0] exp_w [16];

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_ready", 32'(msg_in_ready), 32'd1);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_last",  32'(m_last), 32'd0);
      chk("rst_index", 32'(m_index), 32'd0);
      chk("rst_word",  m_word, 32'd0);
`ifdef MD5_FMT_ERR_EN
      chk("rst_fmt_err", 32'(fmt_err), 32'd0);
`endif
      busy = 0; idx = 0; err_next = 0;
    end else begin
      chk("ready", 32'(msg_in_ready), 32'(!busy));
      chk("valid", 32'(m_valid), 32'(busy));
`ifdef MD5_FMT_ERR_EN
      chk("fmt_err", 32'(fmt_err), 32'(err_next));
      if (fmt_err) err_seen++;
`endif
      err_next = 0;
      if (busy) begin
        chk($sformatf("word%0d", idx), m_word, exp_w[idx]);
        chk("index", 32'(m_index), 32'(idx));
        chk("last", 32'(m_last), 32'(idx == 15));
      end
      if (m_valid && m_ready) dut_acc++;
      if (!busy) begin
        if (msg_in_valid) begin
          for (int i = 0; i < 16; i++) exp_w[i] = mword(msg_in, msg_in_width, i);
          busy = 1; idx = 0;
          err_next = (msg_in_width > 8'd128) || (msg_in_width[2:0] != 3'd0);
        end
      end else if (m_ready) begin
        if (idx == 15) begin busy = 0; idx = 0; end
        else idx++;
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [127:0] m, input logic [7:0] w);
    int t = 0;
    msg_in = m; msg_in_width = w; msg_in_valid = 1'b1;
    @(negedge clock);
    while (!msg_in_ready && t < 400) begin @(negedge clock); t++; end
    if (t >= 400) chk("accept_timeout", 32'(t), 32'd0);
    @(posedge clock); #1;
    msg_in_valid = 1'b0;
    msg_in = {$urandom, $urandom, $urandom, $urandom};
    msg_in_width = 8'($urandom);
    nblocks++;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clock);
    while (!msg_in_ready && t < 400) begin @(negedge clock); t++; end
    if (t >= 400) chk("idle_timeout", 32'(t), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    int a0, n0, e0, t;
    logic [127:0] m;
    logic [7:0] w;
    reset = 1'b1; msg_in = '0; msg_in_width = '0; msg_in_valid = 1'b0;

    // Pin the model against hand-computed vectors.
    chk("model_abc_m0",  mword({24'h616263, 104'h0}, 8'd24, 0),  32'h80636261);
    chk("model_abc_m14", mword({24'h616263, 104'h0}, 8'd24, 14), 32'h00000018);
    chk("model_abc_m15", mword({24'h616263, 104'h0}, 8'd24, 15), 32'h00000000);
    chk("model_w0_m0",   mword(128'h0, 8'd0, 0), 32'h00000080);
    chk("model_w0_m14",  mword(128'h0, 8'd0, 14), 32'h00000000);
    m = "0123456789abcdef";
    chk("model_16b_m0",  mword(m, 8'd128, 0),  32'h33323130);
    chk("model_16b_m4",  mword(m, 8'd128, 4),  32'h00000080);
    chk("model_16b_m14", mword(m, 8'd128, 14), 32'h00000080);
    chk("model_w200_m14", mword(m, 8'd200, 14), 32'h00000080);
    chk("model_w20_m0",  mword(m, 8'd20, 0), 32'h00803130);

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    send({24'h616263, 104'h0}, 8'd24); wait_idle();
    send({$urandom, $urandom, $urandom, $urandom}, 8'd0); wait_idle();
    send("0123456789abcdef", 8'd128); wait_idle();

    // Random messages, random back-pressure, back-to-back requests.
    a0 = dut_acc; n0 = nblocks;
    rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      w = (i % 5 == 4) ? 8'($urandom) : 8'(8 * $urandom_range(0, 16));
      send(m, w);
    end
    wait_idle();
    rand_ready = 0;
    chk("accepted_words", 32'(dut_acc - a0), 32'(16 * (nblocks - n0)));

    // Reset in the middle of a block.
    @(posedge clock); #1;
    send({$urandom, $urandom, $urandom, $urandom}, 8'd64);
    t = 0;
    @(negedge clock);
    while (m_index != 4'd7 && t < 100) begin @(negedge clock); t++; end
    chk("reach_idx7", 32'(t < 100), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(m_valid), 32'd0);
    chk("async_rst_index", 32'(m_index), 32'd0);
    chk("async_rst_ready", 32'(msg_in_ready), 32'd1);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 8'd40); wait_idle();

    // Illegal widths: clamp and truncate.
    e0 = err_seen;
    send("0123456789abcdef", 8'd200); wait_idle();
    send("0123456789abcdef", 8'd20);  wait_idle();
    send("0123456789abcdef", 8'd16);  wait_idle();
`ifdef MD5_FMT_ERR_EN
    chk("fmt_err_pulses", 32'(err_seen - e0), 32'd2);
`else
    chk("fmt_err_pulses", 32'(err_seen - e0), 32'd0);
`endif

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
